ulpi_link: RTL and testbench

- Link-side ULPI controller between a ULPI PHY (8-bit SDR bus, PHY-sourced clock) and the system.
- Performs PHY register writes and reads requested by the system.
- Captures RX CMD bytes and received packet data from the PHY and presents them to the system.
- PHY-side signals form the ulpi_if bundle; system-side signals form the ulpi_link_if bundle.

---
 rtl/ulpi_pkg.sv | 42 ++++
 rtl/ulpi_link_if.sv | 43 ++++
 rtl/ulpi_link_rx.sv | 62 ++++++
 rtl/ulpi_link.sv | 118 +++++++++++
 tb/tb_ulpi_link.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ulpi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ulpi_pkg
// Description : Shared constants, FSM encoding and RX CMD field layout for
//               the link-side ULPI controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ulpi_pkg;

   // TXCMD prefixes placed in bits [7:6] of a link transmit command
   localparam logic [1:0] TXCMD_NOOP = 2'b00;
   localparam logic [1:0] TXCMD_REGW = 2'b10;
   localparam logic [1:0] TXCMD_REGR = 2'b11;

   // Byte the link drives while it owns the bus with nothing to say
   localparam logic [7:0] IDLE_BYTE  = 8'h00;

   // Register access FSM
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_TXCMD  = 3'd1,
      ST_WDATA  = 3'd2,
      ST_WSTP   = 3'd3,
      ST_RTURN  = 3'd4,
      ST_RDATA  = 3'd5,
      ST_RTURNB = 3'd6
   } link_state_t;

   // RX CMD field positions
   localparam int RXCMD_LINESTATE_LSB = 0;
   localparam int RXCMD_VBUS_LSB      = 2;
   localparam int RXCMD_RXEVENT_LSB   = 4;
   localparam int RXCMD_FIELD_W       = 2;

   // Build a transmit command byte from prefix and register address
   function automatic logic [7:0] txcmd_byte(input logic [1:0] prefix,
                                             input logic [5:0] addr);
      return {prefix, addr};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ulpi_link_if.sv
`default_nettype none
// ============================================================================
// Module      : ulpi_if / ulpi_link_if
// Description : PHY-side control bundle (dir/nxt/stp) and system-side
//               register/receive bundle of the ULPI link. The 8-bit data pad
//               is bidirectional and stays a plain inout port of the link.
// Revision    : 1.0 - initial release
// ============================================================================
interface ulpi_if;
   logic dir;
   logic nxt;
   logic stp;

   modport master (output dir, output nxt, input stp);
   modport slave  (input dir, input nxt, output stp);
endinterface

interface ulpi_link_if;
   logic [5:0] reg_addr;
   logic [7:0] reg_data_write;
   logic       reg_read_nwrite;
   logic       reg_enable;
   logic       reg_done;
   logic [7:0] reg_data_read;
   logic [7:0] rx_cmd;
   logic       rx_cmd_valid;
   logic [7:0] rx_data;
   logic       rx_data_valid;

   modport master (
      output reg_addr, output reg_data_write, output reg_read_nwrite,
      output reg_enable,
      input  reg_done, input reg_data_read,
      input  rx_cmd, input rx_cmd_valid, input rx_data, input rx_data_valid
   );
   modport slave (
      input  reg_addr, input reg_data_write, input reg_read_nwrite,
      input  reg_enable,
      output reg_done, output reg_data_read,
      output rx_cmd, output rx_cmd_valid, output rx_data, output rx_data_valid
   );
endinterface
`default_nettype wire

// File: rtl/ulpi_link_rx.sv
`default_nettype none
// ============================================================================
// Module      : ulpi_rx
// Description : Bus turnaround tracker plus capture of RX CMD bytes and
//               received packet bytes while the PHY owns the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module ulpi_rx (
   input  wire logic       clk,
   input  wire logic       reset_n,
   input  wire logic       dir,
   input  wire logic       nxt,
   input  wire logic [7:0] data,
   input  wire logic       suppress,
   output logic            bus_free,
   output logic [7:0]      rx_cmd,
   output logic            rx_cmd_valid,
   output logic [7:0]      rx_data,
   output logic            rx_data_valid
);

   logic       r_dir_q;
   logic [7:0] r_rx_cmd;
   logic       r_rx_cmd_valid;
   logic [7:0] r_rx_data;
   logic       r_rx_data_valid;
   logic       w_rx_sample;

   // Remember last cycle's dir so a change of owner marks a turnaround cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_dir_q <= 1'b0;
      else          r_dir_q <= dir;
   end

   // Link may drive only when dir has been low for two consecutive samples
   assign bus_free    = !dir && !r_dir_q;
   // PHY data is meaningful only after its own turnaround; read replies are
   // consumed by the register FSM instead of being reported here
   assign w_rx_sample = dir && r_dir_q && !suppress;

   // Capture RX CMD (nxt low) or packet byte (nxt high) with a one-cycle pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_cmd        <= 8'h00;
         r_rx_cmd_valid  <= 1'b0;
         r_rx_data       <= 8'h00;
         r_rx_data_valid <= 1'b0;
      end else begin
         r_rx_cmd_valid  <= w_rx_sample && !nxt;
         r_rx_data_valid <= w_rx_sample && nxt;
         if (w_rx_sample && !nxt) r_rx_cmd  <= data;
         if (w_rx_sample && nxt)  r_rx_data <= data;
      end
   end

   assign rx_cmd        = r_rx_cmd;
   assign rx_cmd_valid  = r_rx_cmd_valid;
   assign rx_data       = r_rx_data;
   assign rx_data_valid = r_rx_data_valid;

endmodule
`default_nettype wire

// File: rtl/ulpi_link.sv
`default_nettype none
// ============================================================================
// Module      : ulpi_link
// Description : Link-side ULPI controller: PHY register write/read FSM with
//               abort-and-retry on PHY bus grab, data bus driver, and RX
//               capture through ulpi_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module ulpi_link #(
   parameter logic [7:0] IDLE_BYTE = ulpi_pkg::IDLE_BYTE
) (
   input  wire logic  clk,
   input  wire logic  reset_n,
   inout  wire [7:0]  ulpi_data,
   ulpi_if.slave      ulpi,
   ulpi_link_if.slave sys
);
   import ulpi_pkg::*;

   link_state_t r_state;
   link_state_t w_state_nxt;

   logic [5:0]  r_req_addr;
   logic [7:0]  r_req_wdata;
   logic        r_req_read;
   logic        r_reg_done;
   logic [7:0]  r_reg_data_read;

   logic [7:0]  w_tx_byte;
   logic        w_stp;
   logic        w_bus_free;
   logic        w_accept;

   assign w_accept = (r_state == ST_IDLE) && sys.reg_enable;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state logic; a PHY bus grab during TXCMD/WDATA restarts at TXCMD
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:   if (sys.reg_enable)          w_state_nxt = ST_TXCMD;
         ST_TXCMD:  if (w_bus_free && ulpi.nxt)  w_state_nxt = r_req_read ? ST_RTURN : ST_WDATA;
         ST_WDATA: begin
            if (ulpi.dir)                         w_state_nxt = ST_TXCMD;
            else if (ulpi.nxt)                    w_state_nxt = ST_WSTP;
         end
         ST_WSTP:                                 w_state_nxt = ST_IDLE;
         ST_RTURN:  if (ulpi.dir)                 w_state_nxt = ST_RDATA;
         ST_RDATA:                                w_state_nxt = ST_RTURNB;
         ST_RTURNB: if (!ulpi.dir)                w_state_nxt = ST_IDLE;
         default:                                 w_state_nxt = ST_IDLE;
      endcase
   end

   // Output decode: byte to drive on the bus and the stop strobe
   always_comb begin
      w_tx_byte = IDLE_BYTE;
      w_stp     = 1'b0;
      unique case (r_state)
         ST_TXCMD: if (w_bus_free)
                      w_tx_byte = txcmd_byte(r_req_read ? TXCMD_REGR : TXCMD_REGW, r_req_addr);
         ST_WDATA:  w_tx_byte = r_req_wdata;
         ST_WSTP:   w_stp     = 1'b1;
         default:   w_tx_byte = IDLE_BYTE;
      endcase
   end

   // Latch the request only when idle; strobes in other states are dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_req_addr  <= 6'd0;
         r_req_wdata <= 8'h00;
         r_req_read  <= 1'b0;
      end else if (w_accept) begin
         r_req_addr  <= sys.reg_addr;
         r_req_wdata <= sys.reg_data_write;
         r_req_read  <= sys.reg_read_nwrite;
      end
   end

   // Completion pulse and read result, updated on the same edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_reg_done      <= 1'b0;
         r_reg_data_read <= 8'h00;
      end else begin
         r_reg_done <= (r_state == ST_WSTP) || (r_state == ST_RDATA);
         if (r_state == ST_RDATA) r_reg_data_read <= ulpi_data;
      end
   end

   // Release the pad the instant the PHY takes the bus
   assign ulpi_data         = ulpi.dir ? 8'hzz : w_tx_byte;
   assign ulpi.stp          = w_stp;
   assign sys.reg_done      = r_reg_done;
   assign sys.reg_data_read = r_reg_data_read;

   ulpi_rx u_rx (
      .clk           (clk),
      .reset_n       (reset_n),
      .dir           (ulpi.dir),
      .nxt           (ulpi.nxt),
      .data          (ulpi_data),
      .suppress      (r_state == ST_RDATA),
      .bus_free      (w_bus_free),
      .rx_cmd        (sys.rx_cmd),
      .rx_cmd_valid  (sys.rx_cmd_valid),
      .rx_data       (sys.rx_data),
      .rx_data_valid (sys.rx_data_valid)
   );

endmodule
`default_nettype wire

// File: tb/tb_ulpi_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_ulpi_link
// Description : Directed self-checking bench for ulpi_link with a scripted
//               PHY: RX CMD, packet receive, register write, write collision
//               with retry, and register read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ulpi_link;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] phy_data;
   wire  [7:0] ulpi_data;

   ulpi_if      u_phy ();
   ulpi_link_if u_sys ();

   always #5 clk = ~clk;

   assign ulpi_data = u_phy.dir ? phy_data : 8'hzz;

   ulpi_link #(.IDLE_BYTE(8'h00)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ulpi_data (ulpi_data),
      .ulpi      (u_phy),
      .sys       (u_sys)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n_cmd_v = 0;
   int n_data_v = 0;
   int n_done = 0;
   int n_stp = 0;
   logic [7:0] rx_log[$];

   // Pulse counters sampled mid-cycle
   always @(negedge clk) begin
      if (u_sys.rx_cmd_valid)  n_cmd_v  <= n_cmd_v + 1;
      if (u_sys.reg_done)      n_done   <= n_done + 1;
      if (u_phy.stp)           n_stp    <= n_stp + 1;
      if (u_sys.rx_data_valid) begin
         n_data_v <= n_data_v + 1;
         rx_log.push_back(u_sys.rx_data);
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next negedge and drive the PHY side for the coming edge
   task automatic tick(input logic dir, input logic nxt, input logic [7:0] d);
      @(negedge clk);
      u_sys.reg_enable = 1'b0;
      u_phy.dir        = dir;
      u_phy.nxt        = nxt;
      phy_data         = d;
      #1;
   endtask

   task automatic req(input logic [5:0] addr, input logic [7:0] wd, input logic rd);
      u_sys.reg_addr        = addr;
      u_sys.reg_data_write  = wd;
      u_sys.reg_read_nwrite = rd;
      u_sys.reg_enable      = 1'b1;
   endtask

   task automatic rx_cmd_seq(input logic [7:0] b);
      tick(1'b1, 1'b0, 8'hAA);
      tick(1'b1, 1'b0, b);
      tick(1'b0, 1'b0, 8'h00);
      chk("rxcmd_valid", {15'd0, u_sys.rx_cmd_valid}, 16'd1);
      chk("rxcmd_byte", {8'd0, u_sys.rx_cmd}, {8'd0, b});
      tick(1'b0, 1'b0, 8'h00);
      chk("rxcmd_pulse_end", {15'd0, u_sys.rx_cmd_valid}, 16'd0);
   endtask

   initial begin
      reset_n               = 1'b0;
      u_phy.dir             = 1'b0;
      u_phy.nxt             = 1'b0;
      phy_data              = 8'h00;
      u_sys.reg_addr        = 6'd0;
      u_sys.reg_data_write  = 8'h00;
      u_sys.reg_read_nwrite = 1'b0;
      u_sys.reg_enable      = 1'b0;

      // Reset
      tick(1'b0, 1'b0, 8'h00);
      tick(1'b0, 1'b0, 8'h00);
      chk("rst_data", {8'd0, ulpi_data}, 16'h0000);
      chk("rst_stp", {15'd0, u_phy.stp}, 16'd0);
      chk("rst_done", {15'd0, u_sys.reg_done}, 16'd0);
      chk("rst_cmdv", {15'd0, u_sys.rx_cmd_valid}, 16'd0);
      chk("rst_datav", {15'd0, u_sys.rx_data_valid}, 16'd0);
      chk("rst_rdata", {8'd0, u_sys.reg_data_read}, 16'h0000);
      chk("rst_rxcmd", {8'd0, u_sys.rx_cmd}, 16'h0000);
      chk("rst_rxdata", {8'd0, u_sys.rx_data}, 16'h0000);
      reset_n = 1'b1;
      tick(1'b0, 1'b0, 8'h00);
      chk("idle_data", {8'd0, ulpi_data}, 16'h0000);

      // RX CMD bytes
      rx_cmd_seq(8'h23);
      rx_cmd_seq(8'h42);
      chk("rxcmd_count", n_cmd_v[15:0], 16'd2);
      chk("rxcmd_no_data", n_data_v[15:0], 16'd0);

      // Packet receive followed by an RX CMD
      tick(1'b1, 1'b0, 8'hAA);
      tick(1'b1, 1'b1, 8'h11);
      tick(1'b1, 1'b1, 8'h22);
      chk("pkt_b0", {7'd0, u_sys.rx_data_valid, u_sys.rx_data}, 16'h0111);
      tick(1'b1, 1'b1, 8'h33);
      chk("pkt_b1", {7'd0, u_sys.rx_data_valid, u_sys.rx_data}, 16'h0122);
      tick(1'b1, 1'b1, 8'h44);
      chk("pkt_b2", {7'd0, u_sys.rx_data_valid, u_sys.rx_data}, 16'h0133);
      tick(1'b1, 1'b0, 8'hF0);
      chk("pkt_b3", {7'd0, u_sys.rx_data_valid, u_sys.rx_data}, 16'h0144);
      tick(1'b0, 1'b0, 8'h00);
      chk("pkt_rxcmd", {7'd0, u_sys.rx_cmd_valid, u_sys.rx_cmd}, 16'h01F0);
      chk("pkt_data_end", {15'd0, u_sys.rx_data_valid}, 16'd0);
      tick(1'b0, 1'b0, 8'h00);

      // Register write: addr 1 <= 8'h02
      req(6'd1, 8'h02, 1'b0);
      tick(1'b0, 1'b0, 8'h00);
      chk("wr_txcmd", {8'd0, ulpi_data}, 16'h0081);
      tick(1'b0, 1'b1, 8'h00);
      chk("wr_txcmd_hold", {8'd0, ulpi_data}, 16'h0081);
      tick(1'b0, 1'b1, 8'h00);
      chk("wr_data", {8'd0, ulpi_data}, 16'h0002);
      tick(1'b0, 1'b0, 8'h00);
      chk("wr_stp", {7'd0, u_phy.stp, ulpi_data}, 16'h0100);
      chk("wr_done_early", {15'd0, u_sys.reg_done}, 16'd0);
      tick(1'b0, 1'b0, 8'h00);
      chk("wr_done", {14'd0, u_phy.stp, u_sys.reg_done}, 16'd1);
      tick(1'b0, 1'b0, 8'h00);
      chk("wr_done_end", {15'd0, u_sys.reg_done}, 16'd0);

      // Write collision: PHY grabs the bus during TXCMD, write is retried
      req(6'd3, 8'h04, 1'b0);
      tick(1'b0, 1'b0, 8'h00);
      chk("col_txcmd", {8'd0, ulpi_data}, 16'h0083);
      tick(1'b1, 1'b0, 8'hAA);
      chk("col_release", {8'd0, ulpi_data}, 16'h00AA);
      tick(1'b1, 1'b1, 8'hA1);
      req(6'd9, 8'hFF, 1'b1);
      tick(1'b1, 1'b1, 8'hA2);
      chk("col_pkt0", {7'd0, u_sys.rx_data_valid, u_sys.rx_data}, 16'h01A1);
      tick(1'b1, 1'b1, 8'hA3);
      tick(1'b0, 1'b0, 8'h00);
      tick(1'b0, 1'b0, 8'h00);
      chk("col_retry", {8'd0, ulpi_data}, 16'h0083);
      tick(1'b0, 1'b1, 8'h00);
      chk("col_retry_hold", {8'd0, ulpi_data}, 16'h0083);
      tick(1'b0, 1'b1, 8'h00);
      chk("col_wdata", {8'd0, ulpi_data}, 16'h0004);
      tick(1'b0, 1'b0, 8'h00);
      chk("col_stp", {7'd0, u_phy.stp, ulpi_data}, 16'h0100);
      tick(1'b0, 1'b0, 8'h00);
      chk("col_done", {15'd0, u_sys.reg_done}, 16'd1);
      tick(1'b0, 1'b0, 8'h00);
      chk("col_done_count", n_done[15:0], 16'd2);

      // Register read: addr 6, PHY answers 8'h5A
      req(6'd6, 8'h00, 1'b1);
      tick(1'b0, 1'b0, 8'h00);
      chk("rd_txcmd", {8'd0, ulpi_data}, 16'h00C6);
      tick(1'b0, 1'b1, 8'h00);
      chk("rd_txcmd_hold", {8'd0, ulpi_data}, 16'h00C6);
      tick(1'b1, 1'b0, 8'hAA);
      tick(1'b1, 1'b0, 8'h5A);
      chk("rd_done_early", {15'd0, u_sys.reg_done}, 16'd0);
      tick(1'b0, 1'b0, 8'h00);
      chk("rd_done", {7'd0, u_sys.reg_done, u_sys.reg_data_read}, 16'h015A);
      chk("rd_no_rxcmd", {15'd0, u_sys.rx_cmd_valid}, 16'd0);
      tick(1'b0, 1'b0, 8'h00);
      chk("rd_done_end", {15'd0, u_sys.reg_done}, 16'd0);
      chk("rd_hold", {8'd0, u_sys.reg_data_read}, 16'h005A);
      tick(1'b0, 1'b0, 8'h00);

      // Totals across the run
      chk("tot_done", n_done[15:0], 16'd3);
      chk("tot_stp", n_stp[15:0], 16'd2);
      chk("tot_rxcmd", n_cmd_v[15:0], 16'd3);
      chk("tot_rxdata", n_data_v[15:0], 16'd7);
      chk("last_rxcmd", {8'd0, u_sys.rx_cmd}, 16'h00F0);
      chk("log_size", rx_log.size(), 16'd7);
      if (rx_log.size() == 7) begin
         chk("log0", {8'd0, rx_log[0]}, 16'h0011);
         chk("log1", {8'd0, rx_log[1]}, 16'h0022);
         chk("log2", {8'd0, rx_log[2]}, 16'h0033);
         chk("log3", {8'd0, rx_log[3]}, 16'h0044);
         chk("log4", {8'd0, rx_log[4]}, 16'h00A1);
         chk("log5", {8'd0, rx_log[5]}, 16'h00A2);
         chk("log6", {8'd0, rx_log[6]}, 16'h00A3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
